onehot_event_serializer: RTL

ONEHOT_EVENT_SERIALIZER -- requirements
Module: onehot_event_serializer

---
 rtl/onehot_event_serializer.sv | 90 +++++++++
 1 files changed

// File: rtl/onehot_event_serializer.sv
// Serializes one-hot events into a pending mask and presents them one at a time
// as binary indices, round-robin from just past the last accepted index.
module onehot_event_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_onehot,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  out_idx,
  output logic [15:0] pending,
  output logic        err,
  output logic [7:0]  dup_cnt
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t      state, state_next;
  logic [3:0]  rr_ptr, rr_next, idx_next, sel, probe;
  logic        found, one_hot, cap, bad, pop, dup_hit;
  logic [15:0] pop_mask, pending_next;

  always_comb begin
    one_hot      = (in_onehot != '0) && ((in_onehot & (in_onehot - 16'd1)) == '0);
    cap          = in_valid && one_hot;
    bad          = in_valid && !one_hot;
    pop          = (state == PRESENT) && out_ready;
    pop_mask     = pop ? (16'd1 << out_idx) : '0;
    // Set is OR-ed after the clear so a same-bit capture survives its own pop.
    pending_next = (pending & ~pop_mask) | (cap ? in_onehot : '0);
    dup_hit      = cap && ((pending & in_onehot & ~pop_mask) != '0);
  end

  // First set bit of the registered mask, scanning upward from rr_ptr with wrap.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    probe = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      probe = rr_ptr + i[3:0];
      if (!found && pending[probe]) begin
        sel   = probe;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = out_idx;
    rr_next    = rr_ptr;
    case (state)
      IDLE: begin
        if (found) begin
          idx_next   = sel;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          rr_next    = out_idx + 4'd1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      rr_ptr  <= '0;
      out_idx <= '0;
      err     <= 1'b0;
      dup_cnt <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      rr_ptr  <= rr_next;
      out_idx <= idx_next;
      err     <= err | bad;
      if (dup_hit && (dup_cnt != '1))
        dup_cnt <= dup_cnt + 8'd1;
    end
  end

  assign out_valid = (state == PRESENT);

endmodule
